// File: rtl/dac_wavegen.sv
// -----------------------------------------------------------------------------
// dac_wavegen
//   Waveform driver for a parallel-input current-output DAC. Produces one
//   registered DAC word per clk in one of three modes: steady (live data),
//   sawtooth ramp, or bounded triangle.
//
// Configuration macro:
//   DAC_WAVEGEN_TRIANGLE_EN - when defined, control=2 selects triangle mode and
//                             the TRI_UP/TRI_DN logic is built. When undefined,
//                             control=2 is unsupported and lo/hi are unused.
//
// Ports:
//   clk      in   1       sample clock, rising edge
//   rst_n    in   1       asynchronous active-low reset
//   control  in   CTRL_W  mode: 0 steady, 1 ramp, 2 triangle, other = idle
//   data     in   DATA_W  steady-mode value
//   step     in   DATA_W  ramp/triangle increment per update tick
//   div      in   DIV_W   update tick every div+1 cycles
//   lo, hi   in   DATA_W  triangle bounds
//   dac_in   out  DATA_W  registered DAC word
//   wrap     out  1       one-cycle pulse on ramp overflow / triangle period end
//   active   out  1       high while a waveform state is running
// -----------------------------------------------------------------------------
module dac_wavegen #(
  parameter int DATA_W = 14,
  parameter int CTRL_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] control,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] step,
  input  logic [DIV_W-1:0]  div,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] dac_in,
  output logic              wrap,
  output logic              active
);

  localparam logic [DATA_W-1:0] MID         = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [CTRL_W-1:0] MODE_STEADY = {CTRL_W{1'b0}};
  localparam logic [CTRL_W-1:0] MODE_RAMP   = CTRL_W'(1'b1);
  localparam logic [DIV_W-1:0]  CNT_ZERO    = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0]  CNT_ONE     = DIV_W'(1'b1);
`ifdef DAC_WAVEGEN_TRIANGLE_EN
  localparam logic [CTRL_W-1:0] MODE_TRI    = CTRL_W'(2'd2);
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STEADY = 3'd1,
    ST_RAMP   = 3'd2,
    ST_TRI_UP = 3'd3,
    ST_TRI_DN = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] dac_q, dac_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic              active_q, active_d;

  logic              tick_s;
  logic [DATA_W:0]   sum_s;
`ifdef DAC_WAVEGEN_TRIANGLE_EN
  logic [DATA_W:0]   lo_plus_step_s;
`else
  logic              unused_bounds_s;
  assign unused_bounds_s = ^{lo, hi};
`endif

  // Next-state, next-output and divider computation.
  always_comb begin
    state_d = state_q;
    dac_d   = dac_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    // >= so that lowering div mid-run produces a tick immediately
    tick_s  = (cnt_q >= div);
    // one extra bit keeps the ramp carry and the bound compares exact
    sum_s   = {1'b0, dac_q} + {1'b0, step};
`ifdef DAC_WAVEGEN_TRIANGLE_EN
    lo_plus_step_s = {1'b0, lo} + {1'b0, step};
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        if (control == MODE_STEADY) begin
          state_d = ST_STEADY;
        end else if (control == MODE_RAMP) begin
          state_d = ST_RAMP;
          dac_d   = MID;
`ifdef DAC_WAVEGEN_TRIANGLE_EN
        end else if (control == MODE_TRI) begin
          state_d = ST_TRI_UP;
          dac_d   = lo;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_STEADY: begin
        if (control != MODE_STEADY) begin
          state_d = ST_IDLE;
        end else begin
          dac_d = data;
        end
      end

      ST_RAMP: begin
        if (control != MODE_RAMP) begin
          state_d = ST_IDLE;
        end else if (tick_s) begin
          cnt_d  = CNT_ZERO;
          dac_d  = sum_s[DATA_W-1:0];
          wrap_d = sum_s[DATA_W];
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

`ifdef DAC_WAVEGEN_TRIANGLE_EN
      ST_TRI_UP: begin
        if (control != MODE_TRI) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = tick_s ? CNT_ZERO : (cnt_q + CNT_ONE);
          // degenerate bounds pin the output to lo and freeze the triangle
          if (lo >= hi) begin
            dac_d = lo;
          end else if (tick_s) begin
            if (sum_s >= {1'b0, hi}) begin
              dac_d   = hi;
              state_d = ST_TRI_DN;
            end else begin
              dac_d = sum_s[DATA_W-1:0];
            end
          end else begin
            dac_d = dac_q;
          end
        end
      end

      ST_TRI_DN: begin
        if (control != MODE_TRI) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = tick_s ? CNT_ZERO : (cnt_q + CNT_ONE);
          if (tick_s) begin
            // compare against lo+step rather than dac-step to avoid underflow
            if ({1'b0, dac_q} <= lo_plus_step_s) begin
              dac_d   = lo;
              state_d = ST_TRI_UP;
              wrap_d  = 1'b1;
            end else begin
              dac_d = dac_q - step;
            end
          end else begin
            dac_d = dac_q;
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    active_d = (state_d != ST_IDLE);
  end

  // State, divider and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      dac_q    <= MID;
      cnt_q    <= CNT_ZERO;
      wrap_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dac_q    <= dac_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      active_q <= active_d;
    end
  end

  assign dac_in = dac_q;
  assign wrap   = wrap_q;
  assign active = active_q;

endmodule

// File: tb/tb_dac_wavegen.sv
// -----------------------------------------------------------------------------
// tb_dac_wavegen
//   Directed, table-driven bench for dac_wavegen (default parameters).
//   Triangle checks are compiled when DAC_WAVEGEN_TRIANGLE_EN is defined;
//   otherwise control=2 is checked to leave the block idle.
// -----------------------------------------------------------------------------
module tb_dac_wavegen;

  logic        clk;
  logic        rst_n;
  logic [7:0]  control;
  logic [13:0] data;
  logic [13:0] step;
  logic [15:0] div;
  logic [13:0] lo;
  logic [13:0] hi;
  logic [13:0] dac_in;
  logic        wrap;
  logic        active;

  int checks;
  int errors;

  dac_wavegen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .control (control),
    .data    (data),
    .step    (step),
    .div     (div),
    .lo      (lo),
    .hi      (hi),
    .dac_in  (dac_in),
    .wrap    (wrap),
    .active  (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  control;
    logic [13:0] data;
    logic [13:0] step;
    logic [15:0] div;
    logic [13:0] exp_dac;
    logic        exp_wrap;
    logic        exp_active;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [7:0] c, input logic [13:0] d,
                              input logic [13:0] s, input logic [15:0] dv,
                              input logic [13:0] ed, input logic ew,
                              input logic ea);
    vec_t v;
    v.control = c; v.data = d; v.step = s; v.div = dv;
    v.exp_dac = ed; v.exp_wrap = ew; v.exp_active = ea;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [13:0] ed,
                         input logic ew, input logic ea);
    chk({tag, " dac_in"}, {18'd0, dac_in}, {18'd0, ed});
    chk({tag, " wrap"},   {31'd0, wrap},   {31'd0, ew});
    chk({tag, " active"}, {31'd0, active}, {31'd0, ea});
  endtask

  // one clock edge, then sample 1 time unit later
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; control = 8'd0; data = 14'h0000; step = 14'h0000;
    div = 16'd0; lo = 14'h0000; hi = 14'h0000;

    // steady, then ramp from steady, overflow, divider, div lowered mid-count, unsupported mode
    add(8'd0, 14'h1234, 14'h0000, 16'd0, 14'h1FFF, 1'b0, 1'b1);
    add(8'd0, 14'h1234, 14'h0000, 16'd0, 14'h1234, 1'b0, 1'b1);
    add(8'd0, 14'h0005, 14'h0000, 16'd0, 14'h0005, 1'b0, 1'b1);
    add(8'd1, 14'h0005, 14'h0001, 16'd0, 14'h0005, 1'b0, 1'b0);
    add(8'd1, 14'h0005, 14'h0001, 16'd0, 14'h1FFF, 1'b0, 1'b1);
    add(8'd1, 14'h0005, 14'h0001, 16'd0, 14'h2000, 1'b0, 1'b1);
    add(8'd1, 14'h0005, 14'h0001, 16'd0, 14'h2001, 1'b0, 1'b1);
    add(8'd1, 14'h0005, 14'h1FFE, 16'd0, 14'h3FFF, 1'b0, 1'b1);
    add(8'd1, 14'h0005, 14'h0001, 16'd0, 14'h0000, 1'b1, 1'b1);
    add(8'd1, 14'h0005, 14'h0001, 16'd0, 14'h0001, 1'b0, 1'b1);
    add(8'd1, 14'h0005, 14'h0100, 16'd3, 14'h0001, 1'b0, 1'b1);
    add(8'd1, 14'h0005, 14'h0100, 16'd3, 14'h0001, 1'b0, 1'b1);
    add(8'd1, 14'h0005, 14'h0100, 16'd3, 14'h0001, 1'b0, 1'b1);
    add(8'd1, 14'h0005, 14'h0100, 16'd3, 14'h0101, 1'b0, 1'b1);
    add(8'd1, 14'h0005, 14'h0100, 16'd3, 14'h0101, 1'b0, 1'b1);
    add(8'd1, 14'h0005, 14'h0100, 16'd3, 14'h0101, 1'b0, 1'b1);
    add(8'd1, 14'h0005, 14'h0100, 16'd3, 14'h0101, 1'b0, 1'b1);
    add(8'd1, 14'h0005, 14'h0100, 16'd3, 14'h0201, 1'b0, 1'b1);
    add(8'd1, 14'h0005, 14'h0100, 16'd3, 14'h0201, 1'b0, 1'b1);
    add(8'd1, 14'h0005, 14'h0100, 16'd3, 14'h0201, 1'b0, 1'b1);
    add(8'd1, 14'h0005, 14'h0100, 16'd0, 14'h0301, 1'b0, 1'b1);
    add(8'd5, 14'h0005, 14'h0100, 16'd0, 14'h0301, 1'b0, 1'b0);
    add(8'd5, 14'h0005, 14'h0100, 16'd0, 14'h0301, 1'b0, 1'b0);

    // reset state, sampled while reset is held
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 14'h1FFF, 1'b0, 1'b0);

    // control valid before the first edge after release
    control = vecs[0].control; data = vecs[0].data;
    step = vecs[0].step; div = vecs[0].div;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      control = vecs[i].control; data = vecs[i].data;
      step = vecs[i].step; div = vecs[i].div;
      step_clk();
      chk_out($sformatf("row%0d", i), vecs[i].exp_dac, vecs[i].exp_wrap, vecs[i].exp_active);
    end

    // ramp overflow then asynchronous reset in the middle of the wrap cycle
    control = 8'd1; step = 14'h2001; div = 16'd0;
    step_clk();
    chk_out("ramp entry", 14'h1FFF, 1'b0, 1'b1);
    step_clk();
    chk_out("ramp big wrap", 14'h0000, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async reset", 14'h1FFF, 1'b0, 1'b0);

    // unsupported mode from reset
    control = 8'd5;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      chk_out($sformatf("ctl5 c%0d", i), 14'h1FFF, 1'b0, 1'b0);
    end

    do_reset();
`ifdef DAC_WAVEGEN_TRIANGLE_EN
    // triangle: 0x100 -> 0x280 -> 0x400 -> 0x280 -> 0x100 (wrap) -> 0x280
    lo = 14'h0100; hi = 14'h0400; step = 14'h0180; div = 16'd0; control = 8'd2;
    step_clk();
    chk_out("tri entry", 14'h0100, 1'b0, 1'b1);
    step_clk(); chk_out("tri up1",  14'h0280, 1'b0, 1'b1);
    step_clk(); chk_out("tri top",  14'h0400, 1'b0, 1'b1);
    step_clk(); chk_out("tri dn1",  14'h0280, 1'b0, 1'b1);
    step_clk(); chk_out("tri bot",  14'h0100, 1'b1, 1'b1);
    step_clk(); chk_out("tri up2",  14'h0280, 1'b0, 1'b1);
    lo = 14'h0200; hi = 14'h0200;
    step_clk(); chk_out("tri flat1", 14'h0200, 1'b0, 1'b1);
    step_clk(); chk_out("tri flat2", 14'h0200, 1'b0, 1'b1);
`else
    // triangle not built: control=2 leaves the block idle
    lo = 14'h0100; hi = 14'h0400; step = 14'h0180; div = 16'd0; control = 8'd2;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      chk_out($sformatf("ctl2 c%0d", i), 14'h1FFF, 1'b0, 1'b0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_wavegen.md
# dac_wavegen

Parametrised waveform driver for a parallel-input current-output DAC (DAC904 class and wider). It replaces the fixed 14-bit steady/ramp driver with configurable width, ramp step and update-rate divider, plus a bounded triangle mode. It sits between the AXI control registers and the DAC data pins, and produces one registered DAC word per `clk`.

## Interface
- `DATA_W`, 14: DAC word width.
- `CTRL_W`, 8: mode register width.
- `DIV_W`, 16: update-rate divider width.
- `clk`  in  1: DAC sample clock; all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `control`  in  CTRL_W: mode. 0 = steady, 1 = sawtooth ramp, 2 = triangle; any other value is unsupported.
- `data`  in  DATA_W: steady-mode output value, sampled live.
- `step`  in  DATA_W: ramp/triangle increment per update tick, unsigned.
- `div`  in  DIV_W: an update tick occurs every `div`+1 cycles.
- `lo`, `hi`  in  DATA_W each: triangle bounds, unsigned.
- `dac_in`  out  DATA_W: registered DAC word.
- `wrap`  out  1: one-cycle pulse at each ramp overflow or triangle period completion.
- `active`  out  1: high when the FSM is in STEADY, RAMP, TRI_UP or TRI_DN.

## Operation
- Midscale constant MID = 2^(DATA_W-1)-1. For DATA_W=14 this is 0x1FFF.
- Reset values: `dac_in`=MID, `wrap`=0, `active`=0, FSM=IDLE, tick counter=0.
- FSM states: IDLE, STEADY, RAMP, TRI_UP, TRI_DN.
- **IDLE** transitions:
  - control=0 → STEADY.
  - control=1 → RAMP, with `dac_in`←MID.
  - control=2 → TRI_UP, with `dac_in`←`lo`.
  - Any other value → stay in IDLE; `dac_in` holds.
  - Every IDLE exit clears the tick counter.
- **Any non-IDLE state**: if `control` differs from the state's mode, go to IDLE for one cycle and hold `dac_in`. The new mode is entered from IDLE on the following cycle.
- **STEADY**: `dac_in`←`data` every cycle. The divider is ignored.
- **Tick counter**:
  - Increments every cycle while in RAMP, TRI_UP or TRI_DN.
  - Tick = (cnt >= `div`). On a tick the counter returns to 0.
  - Using >= (not ==) means lowering `div` mid-run takes effect at once.
- **RAMP**: on a tick, {carry, `dac_in`} ← `dac_in`+`step` computed in DATA_W+1 bits. The result wraps modulo 2^DATA_W, and `wrap`=1 for one cycle when carry=1.
- **TRI_UP**:
  - If `lo` >= `hi`: `dac_in`←`lo`; no transitions and no `wrap`.
  - Otherwise, on a tick: if `dac_in`+`step` >= `hi` (DATA_W+1-bit compare), then `dac_in`←`hi` and go to TRI_DN; else add `step`.
- **TRI_DN**:
  - On a tick: if `dac_in` <= `lo`+`step` (DATA_W+1-bit compare), then `dac_in`←`lo`, go to TRI_UP, and pulse `wrap`; else subtract `step`.
  - The output never leaves [`lo`,`hi`].
- **step=0**: RAMP and the triangle states hold `dac_in` on every tick, with no `wrap`. The exception is when `dac_in` already equals a bound; the state then flips, but the value is unchanged.
- `active` is registered and follows the FSM state.

## Timing
- Mode change in a running state: edge 1 → IDLE; edge 2 → new state with its initial value loaded; first update at edge 3 (STEADY) or at the first tick after that.
- Mode change from reset: `control` valid before edge 1 → new state at edge 1.
- STEADY latency: a `data` change appears on `dac_in` one cycle later.
- With `div`=D, consecutive ramp/triangle updates are exactly D+1 cycles apart. The first update comes D+1 cycles after state entry.
- `wrap` is asserted in the same cycle as the `dac_in` value that wrapped or reached `lo`.
- Reset asserted mid-operation forces all reset values immediately (asynchronously). The first state entry can occur at the first edge after deassertion.

## Configuration
- Macro: `DAC_WAVEGEN_TRIANGLE_EN`.
- **Defined**: control=2 selects triangle mode, and the TRI_UP/TRI_DN states and bound comparators are built.
- **Undefined**:
  - control=2 is unsupported; the FSM stays in IDLE with `dac_in` held.
  - `lo` and `hi` are unused.
  - `wrap` is driven only by RAMP.

## Test plan
- Reset, control=0, `data`=0x1234 → `active`=1 after edge 1; `dac_in`=0x1234 at edge 2. Change `data` to 0x0005 → `dac_in`=0x0005 one cycle later.
- control 0→1, `step`=1, `div`=0 → IDLE for one cycle, then `dac_in`=0x1FFF, then 0x2000, 0x2001, … one per cycle. At 0x3FFF→0x0000, `wrap`=1 for exactly one cycle.
- RAMP with `step`=0x100, `div`=3 → updates exactly 4 cycles apart. Set `div`=0 while cnt=2 → the next cycle is a tick.
- Triangle (macro defined), `lo`=0x0100, `hi`=0x0400, `step`=0x0180 → sequence 0x100, 0x280, 0x400, 0x280, 0x100 with `wrap` at the return to 0x100. Set `lo`=`hi`=0x200 → `dac_in` holds at 0x200.
- control=5 from reset → `dac_in` stays 0x1FFF and `active`=0. Assert `rst_n` low mid-ramp → `dac_in`=0x1FFF and `wrap`=0 immediately, without waiting for `clk`.
- Macro undefined, control=2 → FSM remains in IDLE, `dac_in` unchanged, `active`=0.
